lc3_mem_io_responder: RTL
=========================

# lc3_mem_io_responder

Memory-side responder for the SLC-3 CPU's MAR/MDR memory interface. It answers CPU read/write strobes with a fixed-latency ready (R) handshake and drives the external SRAM. It also decodes the memory-mapped I/O address, returning the switches on reads and latching the hex display on writes. It conditions the raw Run/Continue buttons into clean single-cycle pulses for the CPU state controller.

## Interface
Parameters:
- MEM_LATENCY, 2: cycles from first sampled strobe to R assertion; legal range 1–15.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a button level (board build uses 50000).
- IO_ADDR, 16'hFFFF: memory-mapped switch/hex address.

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  system clock; everything is clocked on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ADDR  in  16  address from MAR.
- Data_from_CPU  in  16  write data from MDR.
- Data_to_CPU  out  16  read data to MDR.
- OE  in  1  CPU read strobe, active-high.
- WE  in  1  CPU write strobe, active-high.
- R  out  1  access-complete, one-cycle pulse.
- SRAM_ADDR  out  20  SRAM address.
- SRAM_DQ_in  in  16  SRAM read data.
- SRAM_DQ_out  out  16  SRAM write data.
- SRAM_OE  out  1  SRAM output enable, active-high.
- SRAM_WE  out  1  SRAM write enable, active-high.
- SW  in  10  board switches, asynchronous.
- Run_btn, Continue_btn  in  1 each  raw buttons, active-high after board inversion.
- Run_pulse, Continue_pulse  out  1 each  one-cycle debounced rising-edge pulses.
- hex_display  out  16  value shown on HEX3..HEX0.

## Operation
- Access FSM states: IDLE, ACCESS, DONE.
  - IDLE → ACCESS when OE or WE is sampled high. WE wins if both are high.
  - On entry to ACCESS, latch ADDR, Data_from_CPU and direction, and load the latency counter.
  - ACCESS → DONE when the counter expires. R is high for the single cycle in which DONE is entered.
  - DONE → IDLE only once OE and WE are both low. A held strobe therefore never causes a second access.
- SRAM path (latched address ≠ IO_ADDR):
  - SRAM_ADDR = {4'b0, latched ADDR}.
  - SRAM_OE (read) or SRAM_WE (write) is high throughout ACCESS.
  - For reads, Data_to_CPU captures SRAM_DQ_in on the ACCESS→DONE edge and holds it until the next read completes.
- IO path (latched address == IO_ADDR):
  - SRAM_OE and SRAM_WE stay low.
  - Read: Data_to_CPU = {6'b0, SW_sync}.
  - Write: hex_display = latched data, updated on the ACCESS→DONE edge.
  - Same latency and R behaviour as the SRAM path.
- SW input: 2-flop synchronizer.
- Button conditioning, per button:
  - 2-flop synchronizer, then a stability counter.
  - Accepted level changes only after DEBOUNCE_CYCLES equal consecutive samples.
  - Each 0→1 change of the accepted level produces one pulse. Holding the button produces no repeats.
- Reset (asynchronous):
  - All outputs go to 0, FSM to IDLE, counters and accepted button levels to 0.
  - Reset mid-access aborts the access: no R, SRAM_WE drops immediately, and hex_display is not updated.

## Timing
- Strobe sampled high at edge n → R high in cycle n+MEM_LATENCY only.
- Read data is valid on Data_to_CPU from the same edge on which R rises.
- SRAM_ADDR and SRAM_DQ_out are stable for the whole of ACCESS.
- A strobe that drops during ACCESS does not cancel the access; R still fires.
- Button pulse latency from a clean raw edge is 2 + DEBOUNCE_CYCLES cycles, ±1.
- Any bounce shorter than DEBOUNCE_CYCLES restarts the stability count.
- Pulses are exactly one cycle wide.
- Run and Continue are conditioned independently and may pulse in the same cycle.

## Structure
- Package lc3_io_pkg holds:
  - the access-state enum (IDLE/ACCESS/DONE);
  - the IO_ADDR default;
  - the counter-width constant, $clog2(MEM_LATENCY+1).
- One sub-module, btn_conditioner (synchronizer + debounce + edge pulse), instantiated twice.

## Test plan
- Reset during idle → all outputs 0, hex_display 16'h0000, R low.
- SRAM write: WE with ADDR 16'h3000, data 16'hBEEF, MEM_LATENCY 2 → SRAM_WE high for 2 cycles and SRAM_ADDR 20'h03000. R then pulses once and does not repeat while WE is held.
- SRAM read: OE at ADDR 16'h3000 with the model returning 16'hBEEF → Data_to_CPU 16'hBEEF on the R cycle, and SRAM_WE never high.
- IO: SW 10'h05A, then OE at 16'hFFFF → Data_to_CPU 16'h005A with SRAM strobes low. WE 16'h1234 at 16'hFFFF → hex_display 16'h1234.
- Buttons: Continue_btn bouncing 1-0-1 in single cycles, then held 20 cycles → exactly one Continue_pulse. Simultaneous Run/Continue presses → both pulse.
- Reset asserted mid-ACCESS of a write to 16'hFFFF → no R, hex_display stays 0, and after release the FSM is in IDLE and accepts the next strobe.

Source files
------------

// File: rtl/lc3_mem_io_responder_pkg.sv
// ---------------------------------------------------------------------------
// lc3_io_pkg
// Shared definitions for the SLC-3 memory/IO responder:
//   - access_state_t : states of the memory access handshake FSM
//   - IO_ADDR_DEFAULT: memory-mapped address of the switches / hex display
//   - latCntWidth()  : width of the latency down-counter for a given latency
//   - LAT_CNT_W      : that width for the default latency
// ---------------------------------------------------------------------------
package lc3_io_pkg;

   // IDLE waits for a strobe, ACCESS runs the fixed latency, DONE waits for
   // the CPU to drop its strobes so a held strobe is served only once.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } access_state_t;

   localparam logic [15:0] IO_ADDR_DEFAULT     = 16'hFFFF;
   localparam int          MEM_LATENCY_DEFAULT = 2;

   // Enough bits to hold any value from 0 up to the latency itself.
   function automatic int latCntWidth(input int latency);
      return $clog2(latency + 1);
   endfunction

   localparam int LAT_CNT_W = latCntWidth(MEM_LATENCY_DEFAULT);

endpackage

// File: rtl/lc3_mem_io_responder_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_io_responder_if
// Bundles the CPU MAR/MDR memory handshake and the external SRAM bus.
//   CPU side : ADDR, Data_from_CPU, OE, WE (to responder); Data_to_CPU, R
//   SRAM side: SRAM_ADDR, SRAM_DQ_out, SRAM_OE, SRAM_WE (from responder);
//              SRAM_DQ_in (to responder)
// Modports:
//   slave  - the responder itself
//   master - the CPU plus SRAM environment driving it
// ---------------------------------------------------------------------------
interface lc3_mem_io_responder_if;
   import lc3_io_pkg::*;

   logic [15:0] ADDR;
   logic [15:0] Data_from_CPU;
   logic [15:0] Data_to_CPU;
   logic        OE;
   logic        WE;
   logic        R;
   logic [19:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_in;
   logic [15:0] SRAM_DQ_out;
   logic        SRAM_OE;
   logic        SRAM_WE;

   modport slave (
      input  ADDR, Data_from_CPU, OE, WE, SRAM_DQ_in,
      output Data_to_CPU, R, SRAM_ADDR, SRAM_DQ_out, SRAM_OE, SRAM_WE
   );

   modport master (
      output ADDR, Data_from_CPU, OE, WE, SRAM_DQ_in,
      input  Data_to_CPU, R, SRAM_ADDR, SRAM_DQ_out, SRAM_OE, SRAM_WE
   );

endinterface

// File: rtl/lc3_mem_io_responder_btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Turns one raw, bouncy, asynchronous button into a clean one-cycle pulse on
// each accepted press.
// Ports:
//   Clk, Reset : system clock, asynchronous active-high reset
//   i_btn      : raw button level (active-high)
//   o_pulse    : one-cycle pulse on each accepted 0->1 change
// Parameter:
//   DEBOUNCE_CYCLES : equal consecutive synchronized samples needed before a
//                     new level is accepted
// ---------------------------------------------------------------------------
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int             DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0]  LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_level;
   logic [DW-1:0] r_cnt;
   logic          r_pulse;

   // Two-flop synchronizer feeding a stability counter. The counter only runs
   // while the synchronized sample disagrees with the accepted level, so any
   // sample that agrees again (a bounce) restarts the count from zero. When
   // the count completes, the new level is accepted and a rising acceptance
   // emits a single pulse.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_meta  <= i_btn;
         r_sync  <= r_meta;
         r_pulse <= 1'b0;
         if (r_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_level <= r_sync;
            r_cnt   <= '0;
            r_pulse <= r_sync;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/lc3_mem_io_responder.sv
// ---------------------------------------------------------------------------
// lc3_mem_io_responder
// Memory-side responder for the SLC-3 CPU. Answers OE/WE strobes with a
// fixed-latency R pulse, drives the external SRAM, maps the switches and hex
// display at IO_ADDR, and conditions the Run/Continue buttons.
// Ports:
//   Clk, Reset        : system clock, asynchronous active-high reset
//   bus (slave)       : CPU handshake + SRAM bus (see lc3_mem_io_responder_if)
//   SW                : board switches (asynchronous)
//   Run_btn           : raw Run button, active-high
//   Continue_btn      : raw Continue button, active-high
//   Run_pulse         : one-cycle debounced Run press
//   Continue_pulse    : one-cycle debounced Continue press
//   hex_display       : value shown on HEX3..HEX0
// ---------------------------------------------------------------------------
module lc3_mem_io_responder
   import lc3_io_pkg::*;
#(
   parameter int          MEM_LATENCY     = MEM_LATENCY_DEFAULT,
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter logic [15:0] IO_ADDR         = IO_ADDR_DEFAULT
) (
   input  logic                          Clk,
   input  logic                          Reset,
   lc3_mem_io_responder_if.slave         bus,
   input  logic [9:0]                    SW,
   input  logic                          Run_btn,
   input  logic                          Continue_btn,
   output logic                          Run_pulse,
   output logic                          Continue_pulse,
   output logic [15:0]                   hex_display
);

   localparam int               CNT_W    = latCntWidth(MEM_LATENCY);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

   access_state_t    r_state;
   access_state_t    w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_addr;
   logic [15:0]      r_data;
   logic             r_isWrite;
   logic             r_R;
   logic [15:0]      r_dataToCpu;
   logic [15:0]      r_hex;
   logic [9:0]       r_swMeta;
   logic [9:0]       r_swSync;
   logic             w_strobe;
   logic             w_start;
   logic             w_expire;
   logic             w_isIo;
   logic             w_inAccess;

   assign w_strobe   = bus.OE | bus.WE;
   assign w_start    = (r_state == IDLE) && w_strobe;
   assign w_inAccess = (r_state == ACCESS);
   assign w_expire   = w_inAccess && (r_cnt == '0);
   assign w_isIo     = (r_addr == IO_ADDR);

   // State register for the access handshake.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Once ACCESS starts it runs to completion even if the
   // strobe drops; DONE holds until both strobes are low so a strobe the CPU
   // keeps asserting cannot start a second access.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_strobe) w_nextState = ACCESS;
         ACCESS:  if (r_cnt == '0) w_nextState = DONE;
         DONE:    if (!bus.OE && !bus.WE) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Access datapath. Address, data and direction are frozen on the IDLE to
   // ACCESS edge so the SRAM sees stable values throughout ACCESS; WE takes
   // priority when both strobes are seen together. R and the read/hex results
   // are all registered on the ACCESS to DONE edge, so read data is valid
   // from the same edge on which R rises.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_isWrite   <= 1'b0;
         r_R         <= 1'b0;
         r_dataToCpu <= '0;
         r_hex       <= '0;
      end else begin
         if (w_start) begin
            r_addr    <= bus.ADDR;
            r_data    <= bus.Data_from_CPU;
            r_isWrite <= bus.WE;
            r_cnt     <= LOAD_VAL;
         end else if (w_inAccess && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         r_R <= w_expire;
         if (w_expire) begin
            if (!r_isWrite) begin
               r_dataToCpu <= w_isIo ? {6'b0, r_swSync} : bus.SRAM_DQ_in;
            end else if (w_isIo) begin
               r_hex <= r_data;
            end
         end
      end
   end

   // Switch synchronizer; the switches only matter when an IO read completes.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_swMeta <= '0;
         r_swSync <= '0;
      end else begin
         r_swMeta <= SW;
         r_swSync <= r_swMeta;
      end
   end

   // SRAM strobes are derived from the current state so that an asynchronous
   // reset drops them immediately; the IO address never touches the SRAM.
   assign bus.SRAM_OE     = w_inAccess && !r_isWrite && !w_isIo;
   assign bus.SRAM_WE     = w_inAccess &&  r_isWrite && !w_isIo;
   assign bus.SRAM_ADDR   = {4'b0, r_addr};
   assign bus.SRAM_DQ_out = r_data;
   assign bus.Data_to_CPU = r_dataToCpu;
   assign bus.R           = r_R;
   assign hex_display     = r_hex;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_runBtn (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_btn   (Run_btn),
      .o_pulse (Run_pulse)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_continueBtn (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_btn   (Continue_btn),
      .o_pulse (Continue_pulse)
   );

endmodule
